// File: rtl/temporizador_irrigacao.sv
// Irrigation countdown timer: loads a BCD MM:SS preset on a start edge, counts
// down once per prescaled second, opens the valve while running and pulses fim at 00:00.
module temporizador_irrigacao #(
    parameter int DIV_CLK = 50000000,
    parameter int W_DIV   = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       pausa,
    input  logic       cancelar,
    input  logic [3:0] dez_minutopreset,
    input  logic [3:0] unid_minutopreset,
    input  logic [3:0] dez_segundopreset,
    input  logic [3:0] unid_segundopreset,
    output logic [3:0] dez_minuto,
    output logic [3:0] unid_minuto,
    output logic [3:0] dez_segundo,
    output logic [3:0] unid_segundo,
    output logic       valvula,
    output logic       ocupado,
    output logic       fim,
    output logic       erro_preset
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [W_DIV-1:0] PRESC_LAST = W_DIV'(DIV_CLK - 1);

    state_t           state_q, state_d;
    logic [W_DIV-1:0] presc_q, presc_d;
    logic [3:0]       dm_q, dm_d, um_q, um_d, ds_q, ds_d, us_q, us_d;
    logic             ini_prev_q;
    logic             valv_q, valv_d, ocup_q, ocup_d, fim_q, fim_d, erro_q, erro_d;

    logic             start_edge, tick, terminal, preset_valid, preset_zero;
    logic [3:0]       dm_dec, um_dec, ds_dec, us_dec;
    logic             brw_us, brw_ds, brw_um;

    assign start_edge   = iniciar & ~ini_prev_q;
    assign tick         = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign terminal     = tick && ({dm_q, um_q, ds_q, us_q} == 16'h0001);
    assign preset_valid = (dez_minutopreset <= 4'd9) && (unid_minutopreset <= 4'd9) &&
                          (dez_segundopreset <= 4'd5) && (unid_segundopreset <= 4'd9);
    assign preset_zero  = ({dez_minutopreset, unid_minutopreset,
                            dez_segundopreset, unid_segundopreset} == 16'h0000);

    // One-second BCD decrement; each digit borrows from the next only when it wraps.
    always_comb begin
        brw_us = (us_q == 4'd0);
        us_dec = brw_us ? 4'd9 : us_q - 4'd1;
        brw_ds = brw_us && (ds_q == 4'd0);
        ds_dec = brw_us ? ((ds_q == 4'd0) ? 4'd5 : ds_q - 4'd1) : ds_q;
        brw_um = brw_ds && (um_q == 4'd0);
        um_dec = brw_ds ? ((um_q == 4'd0) ? 4'd9 : um_q - 4'd1) : um_q;
        dm_dec = brw_um ? dm_q - 4'd1 : dm_q;
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dm_d    = dm_q;
        um_d    = um_q;
        ds_d    = ds_q;
        us_d    = us_q;
        fim_d   = 1'b0;
        erro_d  = 1'b0;

        if (cancelar) begin
            state_d = IDLE;
            presc_d = '0;
            dm_d    = 4'd0;
            um_d    = 4'd0;
            ds_d    = 4'd0;
            us_d    = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        dm_d    = dm_dec;
                        um_d    = um_dec;
                        ds_d    = ds_dec;
                        us_d    = us_dec;
                        if (terminal) begin
                            state_d = DONE;
                            fim_d   = 1'b1;
                        end else if (pausa) begin
                            state_d = PAUSE;
                        end
                    end else if (pausa) begin
                        state_d = PAUSE;
                    end else begin
                        presc_d = presc_q + W_DIV'(1);
                    end
                end
                PAUSE: begin
                    if (!pausa) state_d = RUN;
                end
                default: begin
                    // IDLE and DONE both accept a new start.
                    if (start_edge) begin
                        if (preset_valid) begin
                            dm_d    = dez_minutopreset;
                            um_d    = unid_minutopreset;
                            ds_d    = dez_segundopreset;
                            us_d    = unid_segundopreset;
                            presc_d = '0;
                            if (preset_zero) begin
                                state_d = DONE;
                                fim_d   = 1'b1;
                            end else begin
                                state_d = RUN;
                            end
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        valv_d = (state_d == RUN);
        ocup_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            dm_q       <= 4'd0;
            um_q       <= 4'd0;
            ds_q       <= 4'd0;
            us_q       <= 4'd0;
            ini_prev_q <= 1'b0;
            valv_q     <= 1'b0;
            ocup_q     <= 1'b0;
            fim_q      <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dm_q       <= dm_d;
            um_q       <= um_d;
            ds_q       <= ds_d;
            us_q       <= us_d;
            ini_prev_q <= iniciar;
            valv_q     <= valv_d;
            ocup_q     <= ocup_d;
            fim_q      <= fim_d;
            erro_q     <= erro_d;
        end
    end

    assign dez_minuto   = dm_q;
    assign unid_minuto  = um_q;
    assign dez_segundo  = ds_q;
    assign unid_segundo = us_q;
    assign valvula      = valv_q;
    assign ocupado      = ocup_q;
    assign fim          = fim_q;
    assign erro_preset  = erro_q;

endmodule

// File: tb/tb_temporizador_irrigacao.sv
// Bench for temporizador_irrigacao: a seconds-count reference model is compared
// against the DUT every cycle, plus literal checkpoints from the test plan.
module tb_temporizador_irrigacao;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0, pausa = 1'b0, cancelar = 1'b0;
    logic [3:0] p_dm = 4'd0, p_um = 4'd0, p_ds = 4'd0, p_us = 4'd0;
    logic [3:0] dez_minuto, unid_minuto, dez_segundo, unid_segundo;
    logic       valvula, ocupado, fim, erro_preset;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temporizador_irrigacao #(.DIV_CLK(DIV), .W_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .pausa(pausa), .cancelar(cancelar),
        .dez_minutopreset(p_dm), .unid_minutopreset(p_um),
        .dez_segundopreset(p_ds), .unid_segundopreset(p_us),
        .dez_minuto(dez_minuto), .unid_minuto(unid_minuto),
        .dez_segundo(dez_segundo), .unid_segundo(unid_segundo),
        .valvula(valvula), .ocupado(ocupado), .fim(fim), .erro_preset(erro_preset)
    );

    // Reference model: remaining time kept as a plain count of seconds.
    // m_mode: 0 idle, 1 counting, 2 paused, 3 finished.
    int m_mode, m_secs, m_pre, m_load;
    bit m_prev, m_fim, m_err, m_edge, m_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_secs = 0; m_pre = 0;
            m_prev = 0; m_fim = 0; m_err = 0;
        end else begin
            m_edge = iniciar && !m_prev;
            m_ok   = (p_dm <= 9) && (p_um <= 9) && (p_ds <= 5) && (p_us <= 9);
            m_load = (p_dm * 10 + p_um) * 60 + p_ds * 10 + p_us;
            m_fim  = 0;
            m_err  = 0;
            if (cancelar) begin
                m_mode = 0; m_secs = 0; m_pre = 0;
            end else if (m_mode == 1) begin
                if (m_pre == DIV - 1) begin
                    m_pre  = 0;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode = 3; m_fim = 1;
                    end else if (pausa) begin
                        m_mode = 2;
                    end
                end else if (pausa) begin
                    m_mode = 2;
                end else begin
                    m_pre = m_pre + 1;
                end
            end else if (m_mode == 2) begin
                if (!pausa) m_mode = 1;
            end else if (m_edge) begin
                if (m_ok) begin
                    m_secs = m_load;
                    m_pre  = 0;
                    if (m_load == 0) begin
                        m_mode = 3; m_fim = 1;
                    end else begin
                        m_mode = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end
            m_prev = iniciar;
        end
    end

    function automatic logic [19:0] model_vec();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                m_mode == 1, (m_mode == 1) || (m_mode == 2), m_fim, m_err};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {dez_minuto, unid_minuto, dez_segundo, unid_segundo,
                valvula, ocupado, fim, erro_preset};
    endfunction

    task automatic compare_now();
        if (rst_n) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_now();
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [19:0] v);
        checks++;
        if (dut_vec() !== v) begin
            failures++;
            $display("FAIL %s dut=%h expected=%h", name, dut_vec(), v);
        end
        checks++;
        if (model_vec() !== v) begin
            failures++;
            $display("FAIL %s_model model=%h expected=%h", name, model_vec(), v);
        end
    endtask

    task automatic set_preset(input logic [3:0] a, b, c, d);
        p_dm = a; p_um = b; p_ds = c; p_us = d;
    endtask

    task automatic pulse_start();
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
    endtask

    task automatic do_cancel();
        cancelar = 1'b1;
        cyc(1);
        cancelar = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("reset_state", 20'h0);
        rst_n = 1'b1;
        cyc(2);

        // 01:05 with iniciar held high the whole time
        set_preset(0, 1, 0, 5);
        iniciar = 1'b1;
        cyc(1);
        lit("run_entry", {16'h0105, 4'b1100});
        cyc(3);
        lit("before_first_tick", {16'h0105, 4'b1100});
        cyc(1);
        lit("first_tick", {16'h0104, 4'b1100});
        cyc(255);
        lit("last_second", {16'h0001, 4'b1100});
        cyc(1);
        lit("fim_pulse", {16'h0000, 4'b0010});
        cyc(3);
        lit("held_iniciar_single_start", 20'h0);
        iniciar = 1'b0;
        cyc(2);

        // Borrow chain
        set_preset(1, 0, 0, 0);
        pulse_start();
        cyc(4);
        lit("borrow_1000", {16'h0959, 4'b1100});
        do_cancel();
        lit("cancel_run", 20'h0);
        set_preset(0, 0, 1, 0);
        pulse_start();
        cyc(4);
        lit("borrow_0010", {16'h0009, 4'b1100});
        do_cancel();

        // Pause
        set_preset(0, 0, 0, 5);
        pulse_start();
        cyc(8);
        lit("two_ticks", {16'h0003, 4'b1100});
        pausa = 1'b1;
        cyc(20);
        lit("paused_hold", {16'h0003, 4'b0100});
        pausa = 1'b0;
        cyc(12);
        lit("resume_last_second", {16'h0001, 4'b1100});
        cyc(1);
        lit("fim_after_pause", {16'h0000, 4'b0010});
        do_cancel();

        // Invalid and zero presets
        set_preset(0, 4'hA, 0, 0);
        pulse_start();
        lit("erro_0A00", {16'h0000, 4'b0001});
        cyc(1);
        lit("erro_single_pulse", 20'h0);
        set_preset(0, 0, 6, 0);
        pulse_start();
        lit("erro_0060", {16'h0000, 4'b0001});
        cyc(1);
        set_preset(0, 0, 0, 0);
        pulse_start();
        lit("zero_preset_fim", {16'h0000, 4'b0010});
        cyc(1);
        lit("zero_preset_after", 20'h0);
        do_cancel();

        // cancelar on the terminal tick
        set_preset(0, 0, 0, 3);
        pulse_start();
        cyc(11);
        lit("before_terminal", {16'h0001, 4'b1100});
        cancelar = 1'b1;
        cyc(1);
        cancelar = 1'b0;
        lit("cancel_on_terminal", 20'h0);
        cyc(1);
        lit("no_late_fim", 20'h0);

        // Asynchronous reset mid-count
        set_preset(0, 2, 0, 0);
        pulse_start();
        cyc(5);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 20'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(6);
        lit("idle_after_reset", 20'h0);
        pulse_start();
        lit("restart_after_reset", {16'h0200, 4'b1100});
        do_cancel();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            p_dm = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 1)) : 4'd0;
            p_um = 4'($urandom_range(0, 2));
            p_ds = 4'($urandom_range(0, 5));
            p_us = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: p_dm = 4'($urandom_range(10, 15));
                    1: p_um = 4'($urandom_range(10, 15));
                    2: p_ds = 4'($urandom_range(6, 15));
                    default: p_us = 4'($urandom_range(10, 15));
                endcase
            end
            if ($urandom_range(0, 5) == 0) iniciar = ~iniciar;
            if ($urandom_range(0, 11) == 0) pausa = ~pausa;
            cancelar = ($urandom_range(0, 149) == 0);
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
